// File: rtl/result_face_display_if.sv
// Purpose: trigger inputs and display/buzzer outputs of the end-of-game face driver.
// Latency: plain wires, no storage.
// Backpressure: none; triggers are levels held by the game controller.
// Ports: fail/win (controller -> driver), hang/red/green/beep/repeat_rst/busy (driver -> board/controller).
interface result_face_display_if;
  logic       fail;
  logic       win;
  logic [7:0] hang;
  logic [7:0] red;
  logic [7:0] green;
  logic       beep;
  logic       repeat_rst;
  logic       busy;

  // master = game controller side, slave = face driver side
  modport master (
    output fail, win,
    input  hang, red, green, beep, repeat_rst, busy
  );
  modport slave (
    input  fail, win,
    output hang, red, green, beep, repeat_rst, busy
  );
endinterface

// File: rtl/result_face_display.sv
// Purpose: on fail/win, scan a crying (red) or smiling (green) face and beep, then request a game restart.
// Latency: the edge that samples a trigger in IDLE already drives row 0; all outputs are registered.
// Backpressure: restart request is held until both triggers drop; dropping the trigger mid-show aborts.
// Ports: clk, rst_n (sync, active-low); bus.slave carries fail/win in and
//        hang (active-low row), red/green (columns), beep, repeat_rst, busy out.
module result_face_display #(
  parameter int SCAN_DIV       = 1,
  parameter int BEEP_HALF_FAIL = 11,
  parameter int BEEP_HALF_WIN  = 4,
  parameter int SHOW_CYCLES    = 50,
  parameter int CNT_W          = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  result_face_display_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SHOW_FAIL, SHOW_WIN, DONE} state_t;

  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BF_LAST   = CNT_W'(BEEP_HALF_FAIL - 1);
  localparam logic [CNT_W-1:0] BW_LAST   = CNT_W'(BEEP_HALF_WIN - 1);
  localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(SHOW_CYCLES - 1);

  state_t           state_q, state_d;
  logic [2:0]       row_q, row_d;
  logic [CNT_W-1:0] row_div_q, row_div_d;
  logic [CNT_W-1:0] beep_div_q, beep_div_d;
  logic [CNT_W-1:0] show_cnt_q, show_cnt_d;
  logic [CNT_W-1:0] half_last;
  logic             trig;
  logic             beep_q, beep_d;
  logic             rep_q, rep_d;
  logic             busy_q, busy_d;
  logic [7:0]       hang_q, hang_d;
  logic [7:0]       red_q, red_d;
  logic [7:0]       green_q, green_d;

  function automatic logic [7:0] fail_row(input logic [2:0] r);
    case (r)
      3'd0:    fail_row = 8'h81;
      3'd1:    fail_row = 8'h42;
      3'd2:    fail_row = 8'h24;
      3'd3:    fail_row = 8'h42;
      3'd4:    fail_row = 8'h81;
      3'd5:    fail_row = 8'h18;
      3'd6:    fail_row = 8'h24;
      default: fail_row = 8'h42;
    endcase
  endfunction

  function automatic logic [7:0] win_row(input logic [2:0] r);
    case (r)
      3'd1, 3'd2: win_row = 8'h66;
      3'd4:       win_row = 8'h81;
      3'd5:       win_row = 8'h42;
      3'd6:       win_row = 8'h3C;
      default:    win_row = 8'h00;
    endcase
  endfunction

  always_comb begin
    state_d    = state_q;
    row_d      = 3'd0;
    row_div_d  = '0;
    beep_div_d = '0;
    show_cnt_d = '0;
    half_last  = BF_LAST;
    trig       = 1'b0;
    beep_d     = 1'b0;
    rep_d      = 1'b0;
    busy_d     = 1'b0;
    hang_d     = 8'hFF;
    red_d      = 8'h00;
    green_d    = 8'h00;

    unique case (state_q)
      IDLE: begin
        // fail wins a tie; counters default to zero so the show starts clean
        if (bus.fail)     state_d = SHOW_FAIL;
        else if (bus.win) state_d = SHOW_WIN;
      end
      SHOW_FAIL, SHOW_WIN: begin
        // only the trigger that started the show matters; the other is ignored
        trig      = (state_q == SHOW_FAIL) ? bus.fail : bus.win;
        half_last = (state_q == SHOW_FAIL) ? BF_LAST : BW_LAST;
        if (!trig) begin
          state_d = IDLE;
        end else if (show_cnt_q == SHOW_LAST) begin
          state_d = DONE;
          rep_d   = 1'b1;
        end else begin
          show_cnt_d = show_cnt_q + ONE;
          if (row_div_q == SCAN_LAST) begin
            row_d = row_q + 3'd1;
          end else begin
            row_d     = row_q;
            row_div_d = row_div_q + ONE;
          end
          if (beep_div_q == half_last) begin
            beep_d = ~beep_q;
          end else begin
            beep_d     = beep_q;
            beep_div_d = beep_div_q + ONE;
          end
        end
      end
      DONE: begin
        if (!bus.fail && !bus.win) state_d = IDLE;
        else                       rep_d   = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // outputs are derived from the next state so they line up with it
    if (state_d == SHOW_FAIL || state_d == SHOW_WIN) begin
      busy_d = 1'b1;
      hang_d = ~(8'h80 >> row_d);
      if (state_d == SHOW_FAIL) red_d   = fail_row(row_d);
      else                      green_d = win_row(row_d);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      row_q      <= 3'd0;
      row_div_q  <= '0;
      beep_div_q <= '0;
      show_cnt_q <= '0;
      beep_q     <= 1'b0;
      rep_q      <= 1'b0;
      busy_q     <= 1'b0;
      hang_q     <= 8'hFF;
      red_q      <= 8'h00;
      green_q    <= 8'h00;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      row_div_q  <= row_div_d;
      beep_div_q <= beep_div_d;
      show_cnt_q <= show_cnt_d;
      beep_q     <= beep_d;
      rep_q      <= rep_d;
      busy_q     <= busy_d;
      hang_q     <= hang_d;
      red_q      <= red_d;
      green_q    <= green_d;
    end
  end

  assign bus.hang       = hang_q;
  assign bus.red        = red_q;
  assign bus.green      = green_q;
  assign bus.beep       = beep_q;
  assign bus.repeat_rst = rep_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_result_face_display.sv
// Purpose: self-checking bench for result_face_display (default build and a SCAN_DIV=3 build).
// Latency: outputs are sampled 1 time unit after each rising edge.
// Backpressure: not applicable; triggers are driven as levels.
module tb_result_face_display;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  result_face_display_if ifa ();
  result_face_display_if ifb ();

  result_face_display dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa)
  );

  result_face_display #(
    .SCAN_DIV       (3),
    .BEEP_HALF_FAIL (5),
    .BEEP_HALF_WIN  (3),
    .SHOW_CYCLES    (40),
    .CNT_W          (16)
  ) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb)
  );

  always #5 clk = ~clk;

  // {hang, red, green, beep, repeat_rst, busy}
  localparam logic [26:0] IDLE_V = {8'hFF, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
  localparam logic [26:0] DONE_V = {8'hFF, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0};

  logic [7:0] fail_pat [0:7] = '{8'h81, 8'h42, 8'h24, 8'h42, 8'h81, 8'h18, 8'h24, 8'h42};
  logic [7:0] win_pat  [0:7] = '{8'h00, 8'h66, 8'h66, 8'h00, 8'h81, 8'h42, 8'h3C, 8'h00};

  typedef struct {
    logic       f;
    logic       w;
    logic [7:0] hang;
    logic [7:0] red;
    logic [7:0] green;
    logic       beep;
  } vec_t;

  vec_t fail_tab [0:11];
  vec_t win_tab  [0:7];

  function automatic logic [26:0] out_a();
    return {ifa.hang, ifa.red, ifa.green, ifa.beep, ifa.repeat_rst, ifa.busy};
  endfunction

  function automatic logic [26:0] out_b();
    return {ifb.hang, ifb.red, ifb.green, ifb.beep, ifb.repeat_rst, ifb.busy};
  endfunction

  // Expected outputs k edges after show entry, from the timing rules directly.
  function automatic logic [26:0] model(input bit is_fail, input int k, input int scan,
                                        input int half, input int show);
    int         row;
    logic [7:0] hang;
    logic [7:0] pat;
    logic       bp;
    if (k >= show) return DONE_V;
    row  = (k / scan) % 8;
    hang = 8'hFF;
    hang[7 - row] = 1'b0;
    pat  = is_fail ? fail_pat[row] : win_pat[row];
    bp   = ((k / half) % 2) == 1;
    return {hang, is_fail ? pat : 8'h00, is_fail ? 8'h00 : pat, bp, 1'b0, 1'b1};
  endfunction

  task automatic check(input string name, input logic [26:0] act, input logic [26:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (hang,red,green,beep,rep,busy)", name, act, exp);
    end
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit aborted;
    int kind, hold, gap, ab_at;
    bit is_fail, do_abort;

    for (int r = 0; r < 12; r++) begin
      fail_tab[r].f     = 1'b1;
      fail_tab[r].w     = (r == 0);
      fail_tab[r].hang  = ~(8'h80 >> (r % 8));
      fail_tab[r].red   = fail_pat[r % 8];
      fail_tab[r].green = 8'h00;
      fail_tab[r].beep  = (r >= 11);
    end
    fail_tab[0].hang = 8'h7F;  fail_tab[7].hang = 8'hFE;  fail_tab[8].hang = 8'h7F;
    win_tab[0] = '{1'b0, 1'b1, 8'h7F, 8'h00, 8'h00, 1'b0};
    win_tab[1] = '{1'b0, 1'b1, 8'hBF, 8'h00, 8'h66, 1'b0};
    win_tab[2] = '{1'b0, 1'b1, 8'hDF, 8'h00, 8'h66, 1'b0};
    win_tab[3] = '{1'b0, 1'b1, 8'hEF, 8'h00, 8'h00, 1'b0};
    win_tab[4] = '{1'b0, 1'b1, 8'hF7, 8'h00, 8'h81, 1'b1};
    win_tab[5] = '{1'b0, 1'b1, 8'hFB, 8'h00, 8'h42, 1'b1};
    win_tab[6] = '{1'b0, 1'b1, 8'hFD, 8'h00, 8'h3C, 1'b1};
    win_tab[7] = '{1'b0, 1'b1, 8'hFE, 8'h00, 8'h00, 1'b1};

    clk = 1'b0;
    rst_n = 1'b0;
    ifa.fail = 1'b1;  ifa.win = 1'b1;
    ifb.fail = 1'b0;  ifb.win = 1'b0;

    // reset holds everything blank even with both triggers high
    step(); check("reset_a0", out_a(), IDLE_V);
    step(); check("reset_a1", out_a(), IDLE_V);
    check("reset_b", out_b(), IDLE_V);
    rst_n = 1'b1;

    // fail show, default parameters: table-driven first 12 edges
    for (int i = 0; i < 12; i++) begin
      ifa.fail = fail_tab[i].f;
      ifa.win  = fail_tab[i].w;
      step();
      check($sformatf("fail_tab%0d", i), out_a(),
            {fail_tab[i].hang, fail_tab[i].red, fail_tab[i].green, fail_tab[i].beep, 1'b0, 1'b1});
    end
    for (int k = 12; k < 50; k++) begin
      step(); check($sformatf("fail_k%0d", k), out_a(), model(1'b1, k, 1, 11, 50));
    end
    step(); check("fail_done_entry", out_a(), DONE_V);
    for (int i = 0; i < 20; i++) begin
      step(); check("fail_done_hold", out_a(), DONE_V);
    end
    ifa.fail = 1'b0;
    step(); check("fail_done_release", out_a(), IDLE_V);
    step(); check("idle_after_release", out_a(), IDLE_V);

    // win show: table then model; fail raised mid-show must be ignored
    for (int i = 0; i < 8; i++) begin
      ifa.fail = win_tab[i].f;
      ifa.win  = win_tab[i].w;
      step();
      check($sformatf("win_tab%0d", i), out_a(),
            {win_tab[i].hang, win_tab[i].red, win_tab[i].green, win_tab[i].beep, 1'b0, 1'b1});
    end
    for (int k = 8; k < 50; k++) begin
      if (k == 21) ifa.fail = 1'b1;
      step(); check($sformatf("win_k%0d", k), out_a(), model(1'b0, k, 1, 4, 50));
    end
    step(); check("win_done_entry", out_a(), DONE_V);
    ifa.fail = 1'b0;  ifa.win = 1'b0;
    step(); check("win_done_release", out_a(), IDLE_V);

    // abort: drop fail after 20 show clocks
    ifa.fail = 1'b1;
    for (int k = 0; k <= 20; k++) begin
      step(); check($sformatf("abort_k%0d", k), out_a(), model(1'b1, k, 1, 11, 50));
    end
    ifa.fail = 1'b0;
    step(); check("abort_idle", out_a(), IDLE_V);
    for (int i = 0; i < 60; i++) begin
      step(); check("abort_no_restart", out_a(), IDLE_V);
    end

    // reset in the middle of a show
    ifa.fail = 1'b1;
    for (int k = 0; k <= 30; k++) begin
      step(); check($sformatf("midrst_k%0d", k), out_a(), model(1'b1, k, 1, 11, 50));
    end
    rst_n = 1'b0;
    step(); check("midrst_reset", out_a(), IDLE_V);
    ifa.fail = 1'b0;
    step();
    rst_n = 1'b1;
    step(); check("midrst_after", out_a(), IDLE_V);

    // SCAN_DIV=3 build: rows held 3 clocks, row 7 wraps to row 0 at clock 24
    ifb.fail = 1'b1;
    for (int k = 0; k <= 40; k++) begin
      step(); check($sformatf("b_fail_k%0d", k), out_b(), model(1'b1, k, 3, 5, 40));
      if (k == 21) check8("b_row7_start", ifb.hang, 8'hFE);
      if (k == 23) check8("b_row7_end", ifb.hang, 8'hFE);
      if (k == 24) check8("b_row0_wrap", ifb.hang, 8'h7F);
    end
    ifb.fail = 1'b0;
    step(); check("b_fail_release", out_b(), IDLE_V);
    ifb.win = 1'b1;
    for (int k = 0; k <= 40; k++) begin
      step(); check($sformatf("b_win_k%0d", k), out_b(), model(1'b0, k, 3, 3, 40));
    end
    ifb.win = 1'b0;
    step(); check("b_win_release", out_b(), IDLE_V);

    // randomized shows on the default build
    for (int it = 0; it < 30; it++) begin
      kind     = $urandom_range(0, 2);   // 0 fail, 1 win, 2 both
      is_fail  = (kind != 1);
      do_abort = $urandom_range(0, 1) == 1;
      ab_at    = $urandom_range(0, 48);
      aborted  = 1'b0;
      ifa.fail = (kind != 1);
      ifa.win  = (kind != 0);
      for (int k = 0; k <= 50; k++) begin
        step(); check($sformatf("rnd%0d_k%0d", it, k), out_a(), model(is_fail, k, 1, is_fail ? 11 : 4, 50));
        if (do_abort && k == ab_at) begin
          ifa.fail = 1'b0;  ifa.win = 1'b0;
          step(); check($sformatf("rnd%0d_abort", it), out_a(), IDLE_V);
          aborted = 1'b1;
          break;
        end
        if (is_fail) ifa.win  = 1'($urandom_range(0, 1));
        else         ifa.fail = 1'($urandom_range(0, 1));
      end
      if (!aborted) begin
        hold = $urandom_range(0, 5);
        for (int h = 0; h < hold; h++) begin
          step(); check($sformatf("rnd%0d_hold", it), out_a(), DONE_V);
        end
        ifa.fail = 1'b0;  ifa.win = 1'b0;
        step(); check($sformatf("rnd%0d_release", it), out_a(), IDLE_V);
      end
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        step(); check($sformatf("rnd%0d_gap", it), out_a(), IDLE_V);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
